// File: rtl/master_port.sv
// Bus master port: takes one local read/write request, arbitrates for the bus,
// shifts address/data out serially and collects the slave's serial response.
module master_port #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ddone,
  output logic                  derr,
  output logic                  breq,
  input  logic                  bgrant,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid,
  input  logic                  sready
);
  localparam int TX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(TX_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, WAIT, RDATA, DONE} state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [TX_W-1:0]       tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, rx_shift;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  err_d;
  logic                  xfer_d;

  logic                  dready_q, ddone_q, derr_q, breq_q;
  logic                  mwdata_q, mmode_q, mvalid_q;
  logic [DATA_WIDTH-1:0] drdata_q;

  // Received bits enter at the top so the first bit ends up in bit 0.
  assign rx_shift = (rx_q >> 1) | (DATA_WIDTH'(srdata) << (DATA_WIDTH - 1));
  assign xfer_d   = (state_d == ADDR) || (state_d == WDATA);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    wdata_d   = wdata_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dvalid) begin
          state_d = REQ;
          mode_d  = dmode;
          wdata_d = dwdata;
          tx_d    = '0;
          tx_d[ADDR_WIDTH-1:0] = daddr;
        end
      end
      REQ: begin
        if (bgrant) begin
          state_d   = ADDR;
          bit_cnt_d = '0;
        end
      end
      ADDR, WDATA: begin
        if (!bgrant) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tx_d      = tx_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (state_q == ADDR && bit_cnt_q == ADDR_LAST) begin
            bit_cnt_d = '0;
            tmo_d     = '0;
            if (mode_q) begin
              state_d = WDATA;
              tx_d    = '0;
              tx_d[DATA_WIDTH-1:0] = wdata_q;
            end else begin
              state_d = WAIT;
            end
          end else if (state_q == WDATA && bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            tmo_d     = '0;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (mode_q && sready) begin
          state_d = DONE;
        end else if (!mode_q && svalid) begin
          rx_d      = rx_shift;
          bit_cnt_d = CNT_W'(1);
          state_d   = (DATA_WIDTH == 1) ? DONE : RDATA;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RDATA: begin
        if (svalid) begin
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == DATA_LAST) state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      wdata_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      dready_q  <= 1'b1;
      breq_q    <= 1'b0;
      mvalid_q  <= 1'b0;
      mwdata_q  <= 1'b0;
      mmode_q   <= 1'b0;
      ddone_q   <= 1'b0;
      derr_q    <= 1'b0;
      drdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      wdata_q   <= wdata_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      dready_q  <= (state_d == IDLE);
      breq_q    <= (state_d != IDLE);
      mvalid_q  <= xfer_d;
      mwdata_q  <= xfer_d & tx_d[0];
      mmode_q   <= xfer_d & mode_d;
      ddone_q   <= (state_d == DONE);
      derr_q    <= err_d;
      if (state_d == DONE && !mode_q) drdata_q <= rx_d;
    end
  end

  assign dready = dready_q;
  assign breq   = breq_q;
  assign mvalid = mvalid_q;
  assign mwdata = mwdata_q;
  assign mmode  = mmode_q;
  assign ddone  = ddone_q;
  assign derr   = derr_q;
  assign drdata = drdata_q;

endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: a per-cycle device/arbiter/slave driver feeds each
// scenario; expectations come from the serial-protocol rules as plain arithmetic.
module tb_master_port;
  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dvalid = 1'b0, dmode = 1'b0, bgrant = 1'b0;
  logic          srdata = 1'b0, svalid = 1'b0, sready = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dwdata = '0;
  logic          dready, ddone, derr, breq, mwdata, mmode, mvalid;
  logic [DW-1:0] drdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] last_rd = '0;

  // Observations gathered by run_txn
  logic [63:0]   obs_bits;
  int            n_bits, first_mv, end_cyc, mmode_bad, mwdata_bad, breq_bad, post_ddone;
  logic          got_done, got_err, start_dready, end_breq, end_mvalid;
  logic          post_dready, post_breq, post_derr;
  logic [DW-1:0] rd_val;
  logic [14:0]   snap;

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .dvalid(dvalid), .dmode(dmode), .daddr(daddr), .dwdata(dwdata),
    .dready(dready), .drdata(drdata), .ddone(ddone), .derr(derr), .breq(breq), .bgrant(bgrant),
    .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid), .srdata(srdata), .svalid(svalid), .sready(sready)
  );

  always #5 clk = ~clk;

  // Cycle c=0 is the first cycle after the request is accepted.
  task automatic run_txn(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd, input int gd, input int lat, input logic [31:0] gaps,
                         input int drop_at, input int rst_at, input int dv_at, input int post);
    logic seen_mv;
    int   wc, rb;
    obs_bits = '0; n_bits = 0; first_mv = -1; end_cyc = -1; mmode_bad = 0; mwdata_bad = 0;
    breq_bad = 0; post_ddone = 0; got_done = 0; got_err = 0; rd_val = '0; snap = '0;
    end_breq = 1'bx; end_mvalid = 1'bx; post_dready = 1'bx; post_breq = 1'bx; post_derr = 1'bx;
    seen_mv = 0; wc = 0; rb = 0;
    @(negedge clk);
    start_dready = dready;
    dvalid = 1'b1; dmode = m; daddr = a; dwdata = wd;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      dvalid = 1'b0; daddr = AW'($urandom); dwdata = DW'($urandom); dmode = 1'($urandom);
      if (rst_at >= 0 && c == rst_at + 1) begin
        snap = {dready, breq, mvalid, mwdata, mmode, ddone, derr, drdata};
        rst = 1'b0; end_cyc = c;
        break;
      end
      if (mvalid === 1'b1) begin
        obs_bits[n_bits] = mwdata; n_bits++;
        if (first_mv < 0) first_mv = c;
        seen_mv = 1;
        if (mmode !== m) mmode_bad++;
      end else if (mwdata !== 1'b0) mwdata_bad++;
      if (derr !== 1'b1 && breq !== 1'b1) breq_bad++;
      if (ddone === 1'b1) begin
        got_done = 1; rd_val = drdata; end_cyc = c; end_breq = breq; end_mvalid = mvalid;
        break;
      end
      if (derr === 1'b1) begin
        got_err = 1; end_cyc = c; end_breq = breq; end_mvalid = mvalid;
        break;
      end
      bgrant = (c >= gd) && !(drop_at >= 0 && c >= drop_at);
      if (dv_at >= 0 && c == dv_at) begin dvalid = 1'b1; dmode = ~m; end
      if (rst_at >= 0 && c == rst_at) rst = 1'b1;
      svalid = 1'b0; sready = 1'b0; srdata = 1'($urandom);
      if (seen_mv && mvalid !== 1'b1) begin
        if (wc >= lat) begin
          if (m) sready = 1'b1;
          else if (rb < DW && !((wc - lat) < 32 && gaps[wc - lat])) begin
            svalid = 1'b1; srdata = rd[rb]; rb++;
          end
        end
        wc++;
      end
    end
    dvalid = 1'b0; svalid = 1'b0; sready = 1'b0;
    for (int p = 0; p < post; p++) begin
      @(negedge clk);
      if (p == 0) begin post_dready = dready; post_breq = breq; post_derr = derr; end
      post_ddone += int'(ddone);
    end
    $display("[TB] txn mode=%0b addr=%h wdata=%h rdata=%h gd=%0d lat=%0d -> done=%0b err=%0b bits=%0d end=%0d drdata=%h",
             m, a, wd, rd, gd, lat, got_done, got_err, n_bits, end_cyc, rd_val);
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({dready, breq, mvalid, mwdata, mmode, ddone, derr, drdata} !== 15'h4000) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 4000", {dready, breq, mvalid, mwdata, mmode, ddone, derr, drdata});
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dready !== 1'b1 || breq !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got dready=%b breq=%b expected 1 0", dready, breq);
    end
  endtask

  task automatic test_write;
    logic [63:0] exp;
    exp = 64'(14'h1A5C) | (64'(8'h3C) << AW);
    run_txn(1'b1, 14'h1A5C, 8'h3C, 8'h00, 3, 2, 32'h0, -1, -1, -1, 2);
    n_tests++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL wr_done: got %b expected 1", got_done); end
    n_tests++; if (n_bits != AW + DW) begin n_fail++; $display("FAIL wr_nbits: got %0d expected %0d", n_bits, AW + DW); end
    n_tests++; if (obs_bits !== exp) begin n_fail++; $display("FAIL wr_bits: got %h expected %h", obs_bits, exp); end
    n_tests++; if (first_mv != 4) begin n_fail++; $display("FAIL wr_grant_latency: got %0d expected 4", first_mv); end
    n_tests++; if (end_cyc != 4 + AW + DW + 2 + 1) begin n_fail++; $display("FAIL wr_done_cycle: got %0d expected %0d", end_cyc, 4 + AW + DW + 3); end
    n_tests++; if (breq_bad + mmode_bad + mwdata_bad != 0) begin n_fail++; $display("FAIL wr_bus_signals: got %0d bad cycles expected 0", breq_bad + mmode_bad + mwdata_bad); end
    n_tests++; if (rd_val !== last_rd) begin n_fail++; $display("FAIL wr_drdata_kept: got %h expected %h", rd_val, last_rd); end
    n_tests++; if ({post_breq, post_dready, post_ddone[0]} !== 3'b010) begin n_fail++; $display("FAIL wr_release: got %b expected 010", {post_breq, post_dready, post_ddone[0]}); end
  endtask

  task automatic test_read;
    run_txn(1'b0, 14'h0005, 8'h00, 8'hA7, 1, 2, 32'h4, -1, -1, -1, 1);
    n_tests++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL rd_done: got %b expected 1", got_done); end
    n_tests++; if (rd_val !== 8'hA7) begin n_fail++; $display("FAIL rd_data: got %h expected a7", rd_val); end
    n_tests++; if (n_bits != AW || obs_bits !== 64'h5) begin n_fail++; $display("FAIL rd_addr_bits: got %0d bits %h expected 14 bits 5", n_bits, obs_bits); end
    // one gap among the 8 bits: done one cycle later than a gap-free response
    n_tests++; if (end_cyc != 2 + AW + 2 + DW + 1) begin n_fail++; $display("FAIL rd_done_cycle: got %0d expected %0d", end_cyc, 2 + AW + 2 + DW + 1); end
    n_tests++; if (post_ddone != 0) begin n_fail++; $display("FAIL rd_ddone_pulse: got %0d extra expected 0", post_ddone); end
    last_rd = 8'hA7;
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 14'h2222, 8'h00, 8'h00, 0, 100000, 32'h0, -1, -1, -1, 2);
    n_tests++; if (got_err !== 1'b1 || got_done !== 1'b0) begin n_fail++; $display("FAIL tmo_err: got err=%b done=%b expected 1 0", got_err, got_done); end
    n_tests++; if (end_cyc != 1 + AW + TMO) begin n_fail++; $display("FAIL tmo_cycle: got %0d expected %0d", end_cyc, 1 + AW + TMO); end
    n_tests++; if ({post_dready, post_derr, end_breq} !== 3'b100) begin n_fail++; $display("FAIL tmo_after: got %b expected 100", {post_dready, post_derr, end_breq}); end
  endtask

  task automatic test_grant_loss;
    run_txn(1'b1, 14'h3FFF, 8'hFF, 8'h00, 2, 0, 32'h0, 2 + 1 + 4, -1, -1, 4);
    n_tests++; if (got_err !== 1'b1) begin n_fail++; $display("FAIL gl_err: got %b expected 1", got_err); end
    n_tests++; if (end_cyc != 2 + 1 + 5 || n_bits != 5) begin n_fail++; $display("FAIL gl_timing: got end=%0d bits=%0d expected 8 5", end_cyc, n_bits); end
    n_tests++; if ({end_mvalid, end_breq} !== 2'b00) begin n_fail++; $display("FAIL gl_bus_idle: got %b expected 00", {end_mvalid, end_breq}); end
    n_tests++; if (post_ddone != 0 || post_derr !== 1'b0) begin n_fail++; $display("FAIL gl_no_done: got ddone=%0d derr=%b expected 0 0", post_ddone, post_derr); end
  endtask

  task automatic test_reset_mid_wdata;
    logic [63:0] exp;
    run_txn(1'b1, 14'h0ABC, 8'h5A, 8'h00, 1, 0, 32'h0, -1, 1 + 1 + AW + 2, -1, 0);
    n_tests++; if (snap !== 15'h4000) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 4000", snap); end
    last_rd = '0;
    exp = 64'(14'h1234) | (64'(8'hC3) << AW);
    run_txn(1'b1, 14'h1234, 8'hC3, 8'h00, 0, 1, 32'h0, -1, -1, -1, 1);
    n_tests++; if (got_done !== 1'b1 || obs_bits !== exp) begin n_fail++; $display("FAIL rst_mid_recover: got done=%b bits=%h expected 1 %h", got_done, obs_bits, exp); end
    n_tests++; if (rd_val !== 8'h00) begin n_fail++; $display("FAIL rst_mid_drdata: got %h expected 00", rd_val); end
  endtask

  task automatic test_ignored_request;
    run_txn(1'b0, 14'h2C31, 8'h00, 8'h3E, 0, 0, 32'h0, -1, -1, 1 + 2, 1);
    n_tests++; if (got_done !== 1'b1 || n_bits != AW || obs_bits !== 64'h2C31) begin
      n_fail++; $display("FAIL ignored_req: got done=%b bits=%0d addr=%h expected 1 14 2c31", got_done, n_bits, obs_bits);
    end
    n_tests++; if (rd_val !== 8'h3E) begin n_fail++; $display("FAIL ignored_req_data: got %h expected 3e", rd_val); end
    last_rd = 8'h3E;
  endtask

  task automatic test_back_to_back;
    run_txn(1'b1, 14'h0F0F, 8'h81, 8'h00, 0, 0, 32'h0, -1, -1, -1, 0);
    n_tests++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %b expected 1", got_done); end
    run_txn(1'b0, 14'h30F0, 8'h00, 8'h96, 1, 0, 32'h0, -1, -1, -1, 1);
    n_tests++; if (start_dready !== 1'b1 || first_mv != 2) begin n_fail++; $display("FAIL b2b_accept: got dready=%b first_mv=%0d expected 1 2", start_dready, first_mv); end
    n_tests++; if (got_done !== 1'b1 || rd_val !== 8'h96) begin n_fail++; $display("FAIL b2b_second: got done=%b data=%h expected 1 96", got_done, rd_val); end
    last_rd = 8'h96;
  endtask

  task automatic test_random;
    logic          m;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    logic [31:0]   gaps;
    logic [63:0]   exp;
    int            gd, lat, k, idx, exp_end;
    for (int t = 0; t < 8; t++) begin
      m = 1'($urandom); a = AW'($urandom); wd = DW'($urandom); rd = DW'($urandom);
      gd = $urandom_range(0, 4); lat = $urandom_range(0, 4); gaps = $urandom & 32'h0000_0FFF;
      exp = 64'(a) | (m ? (64'(wd) << AW) : 64'd0);
      if (m) exp_end = gd + 1 + AW + DW + lat + 1;
      else begin
        k = 0; idx = 0;
        while (k < DW) begin
          if (!(idx < 32 && gaps[idx])) k++;
          idx++;
        end
        exp_end = gd + 1 + AW + lat + idx;
      end
      run_txn(m, a, wd, rd, gd, lat, gaps, -1, -1, -1, 1);
      n_tests++; if (got_done !== 1'b1 || end_cyc != exp_end) begin n_fail++; $display("FAIL rand_done[%0d]: got done=%b at %0d expected 1 at %0d", t, got_done, end_cyc, exp_end); end
      n_tests++; if (obs_bits !== exp || n_bits != AW + (m ? DW : 0)) begin n_fail++; $display("FAIL rand_bits[%0d]: got %h (%0d) expected %h", t, obs_bits, n_bits, exp); end
      n_tests++; if (rd_val !== (m ? last_rd : rd)) begin n_fail++; $display("FAIL rand_drdata[%0d]: got %h expected %h", t, rd_val, m ? last_rd : rd); end
      n_tests++; if (breq_bad + mmode_bad + mwdata_bad != 0 || post_breq !== 1'b0) begin n_fail++; $display("FAIL rand_bus[%0d]: got %0d bad cycles breq_after=%b expected 0 0", t, breq_bad + mmode_bad + mwdata_bad, post_breq); end
      if (!m) last_rd = rd;
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_grant_loss;
    test_reset_mid_wdata;
    test_ignored_request;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
